// File: rtl/qspi_pkg.sv
// Shared definitions for the Q-SPI execute-in-place reader.
// Holds the FSM states, opcode and mode constants, phase lengths and helper functions.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_MODE  = 3'd3,
        ST_DUMMY = 3'd4,
        ST_DATA  = 3'd5,
        ST_CSHI  = 3'd6
    } state_e;

    localparam logic [7:0] CMD_QUAD_READ = 8'hEB;
    localparam logic [7:0] MODE_BYTE     = 8'hFF;

    localparam logic [7:0] CMD_CLKS  = 8'd8;
    localparam logic [7:0] ADDR_CLKS = 8'd6;
    localparam logic [7:0] MODE_CLKS = 8'd2;
    localparam logic [7:0] DATA_CLKS = 8'd8;

    // WP/HOLD high on IO3/IO2 whenever the bus is not in a quad phase.
    localparam logic [3:0] IO_IDLE     = 4'b1100;
    localparam logic [3:0] OE_CMD      = 4'b1101;
    localparam logic [3:0] OE_QUAD_OUT = 4'b1111;
    localparam logic [3:0] OE_QUAD_IN  = 4'b0000;

    function automatic logic [23:0] flash_addr(input logic [23:0] addr, input logic [23:0] base);
        return {addr[23:2], 2'b00} + base;
    endfunction

    // The first byte off the wire is the least significant byte of the word.
    function automatic logic [31:0] stream_to_word(input logic [31:0] stream);
        return {stream[7:0], stream[15:8], stream[23:16], stream[31:24]};
    endfunction

endpackage

// File: rtl/qspi_sck_gen.sv
// SPI mode-0 serial clock generator: SCK toggles every HALF_PERIOD cycles while enabled
// and idles low; rise/fall flag the clock edge on which SCK will change.
module qspi_sck_gen #(
    parameter int HALF_PERIOD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          edge_s;

    // Half-period counter and SCK toggle.
    always_comb begin
        edge_s = en && (cnt_q == CNT_LAST);
        if (!en) begin
            cnt_d = {CW{1'b0}};
            sck_d = 1'b0;
        end else if (edge_s) begin
            cnt_d = {CW{1'b0}};
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
            sck_d = sck_q;
        end
    end

    // SCK state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck  = sck_q;
    assign rise = edge_s && !sck_q;
    assign fall = edge_s && sck_q;

endmodule

// File: rtl/qspi_xip_reader.sv
// Instruction-fetch responder: serves 32-bit words from a one-word buffer and refills it
// on a miss with a Fast Read Quad I/O (0xEB) transaction to the configuration flash.
module qspi_xip_reader
    import qspi_pkg::*;
#(
    parameter int          HALF_PERIOD    = 1,
    parameter logic [23:0] BASE_OFFSET    = 24'h080000,
    parameter int          CS_HIGH_CYCLES = 4,
    parameter int          DUMMY_CLKS     = 4
) (
    input  logic        iCLK,
    input  logic        iRESETn,
    input  logic [31:0] iADDR,
    output logic [31:0] oDATA,
    output logic        oSTALL,
    output logic        oFLASH_SCK,
    output logic        oFLASH_CS,
    output logic [3:0]  oIO_OUT,
    output logic [3:0]  oIO_OE,
    input  logic [3:0]  iIO_IN
);

    localparam logic [7:0] DUMMY_LEN = 8'(DUMMY_CLKS);
    localparam logic [7:0] CSHI_LAST = 8'(CS_HIGH_CYCLES - 1);

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic [21:0] ptag_q, ptag_d;
    logic [21:0] tag_q, tag_d;
    logic [23:0] fa_q, fa_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [31:0] sh_q, sh_d;
    logic        cs_q, cs_d;
    logic [3:0]  io_out_q, io_out_d;
    logic [3:0]  io_oe_q, io_oe_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  hold_q, hold_d;

    logic        sck_s, rise_s, fall_s, hit_s;
    logic [7:0]  plen_s;
    logic        unused_addr_s;

    qspi_sck_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_sck_gen (
        .clk   (iCLK),
        .rst_n (iRESETn),
        .en    (~cs_q),
        .sck   (sck_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    assign hit_s         = valid_q && (tag_q == iADDR[23:2]);
    assign unused_addr_s = ^{iADDR[31:24], iADDR[1:0]};

    // SCK cycles in the current phase.
    always_comb begin
        case (state_q)
            ST_CMD:   plen_s = CMD_CLKS;
            ST_ADDR:  plen_s = ADDR_CLKS;
            ST_MODE:  plen_s = MODE_CLKS;
            ST_DUMMY: plen_s = DUMMY_LEN;
            ST_DATA:  plen_s = DATA_CLKS;
            default:  plen_s = 8'd0;
        endcase
    end

    // Transaction sequencer and nibble shifter.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ptag_d   = ptag_q;
        tag_d    = tag_q;
        fa_d     = fa_q;
        valid_d  = valid_q;
        data_d   = data_q;
        sh_d     = sh_q;
        cs_d     = cs_q;
        io_out_d = io_out_q;
        io_oe_d  = io_oe_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        case (state_q)
            ST_IDLE: begin
                // Once latched the fetch is committed, even if iADDR moves on.
                if (pend_q) begin
                    pend_d   = 1'b0;
                    cs_d     = 1'b0;
                    state_d  = ST_CMD;
                    cnt_d    = 8'd0;
                    sh_d     = {CMD_QUAD_READ, 24'h000000};
                    io_oe_d  = OE_CMD;
                    io_out_d = {3'b110, CMD_QUAD_READ[7]};
                end else if (!hit_s) begin
                    pend_d = 1'b1;
                    ptag_d = iADDR[23:2];
                    fa_d   = flash_addr(iADDR[23:0], BASE_OFFSET);
                end else begin
                    pend_d = 1'b0;
                end
            end
            ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA: begin
                if (rise_s) begin
                    cnt_d = cnt_q + 8'd1;
                    sh_d  = (state_q == ST_DATA) ? {sh_q[27:0], iIO_IN} : sh_q;
                end else if (fall_s) begin
                    if (cnt_q == plen_s) begin
                        cnt_d = 8'd0;
                        case (state_q)
                            ST_CMD: begin
                                state_d  = ST_ADDR;
                                sh_d     = {fa_q, 8'h00};
                                io_out_d = fa_q[23:20];
                                io_oe_d  = OE_QUAD_OUT;
                            end
                            ST_ADDR: begin
                                state_d  = ST_MODE;
                                sh_d     = {MODE_BYTE, 24'h000000};
                                io_out_d = MODE_BYTE[7:4];
                                io_oe_d  = OE_QUAD_OUT;
                            end
                            ST_MODE: begin
                                state_d  = (DUMMY_LEN == 8'd0) ? ST_DATA : ST_DUMMY;
                                io_out_d = IO_IDLE;
                                io_oe_d  = OE_QUAD_IN;
                            end
                            ST_DUMMY: begin
                                state_d = ST_DATA;
                            end
                            ST_DATA: begin
                                data_d   = stream_to_word(sh_q);
                                tag_d    = ptag_q;
                                valid_d  = 1'b1;
                                cs_d     = 1'b1;
                                io_out_d = IO_IDLE;
                                io_oe_d  = IO_IDLE;
                                hold_d   = 8'd0;
                                state_d  = ST_CSHI;
                            end
                            default: begin
                                state_d = ST_IDLE;
                            end
                        endcase
                    end else begin
                        case (state_q)
                            ST_CMD: begin
                                sh_d     = sh_q << 1;
                                io_out_d = {3'b110, sh_q[30]};
                            end
                            ST_ADDR, ST_MODE: begin
                                sh_d     = sh_q << 4;
                                io_out_d = sh_q[27:24];
                            end
                            default: begin
                                sh_d = sh_q;
                            end
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_CSHI: begin
                if (hold_q == CSHI_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, buffer and pin registers.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            ptag_q   <= 22'd0;
            tag_q    <= 22'd0;
            fa_q     <= 24'd0;
            valid_q  <= 1'b0;
            data_q   <= 32'd0;
            sh_q     <= 32'd0;
            cs_q     <= 1'b1;
            io_out_q <= IO_IDLE;
            io_oe_q  <= IO_IDLE;
            cnt_q    <= 8'd0;
            hold_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            ptag_q   <= ptag_d;
            tag_q    <= tag_d;
            fa_q     <= fa_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            sh_q     <= sh_d;
            cs_q     <= cs_d;
            io_out_q <= io_out_d;
            io_oe_q  <= io_oe_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
        end
    end

    assign oSTALL     = ~hit_s;
    assign oDATA      = data_q;
    assign oFLASH_CS  = cs_q;
    assign oFLASH_SCK = sck_s;
    assign oIO_OUT    = io_out_q;
    assign oIO_OE     = io_oe_q;

endmodule

// File: tb/tb_qspi_xip_reader.sv
// Randomized self-checking bench: a behavioural Q-SPI flash plus a one-word buffer model
// predict stall lengths, flash addresses and returned instruction words.
module tb_qspi_xip_reader;

    localparam logic [31:0] BASE      = 32'h0008_0000;
    localparam int          MISS_LAT  = 58;
    localparam int          CS_HIGH   = 4;
    localparam int          LAT_BOUND = 400;

    logic        clk;
    logic        rst_n;
    logic [31:0] iaddr;
    logic [31:0] odata;
    logic        ostall;
    logic        sck;
    logic        cs;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic [3:0]  io_in;

    int n_vec;
    int n_err;

    logic [31:0] seed;
    logic        buf_valid;
    logic [21:0] buf_tag;
    logic [31:0] buf_word;
    logic [31:0] last_addr;

    logic [23:0] fa_log[$];
    int          n_txn;
    int          n_abort;
    int          hi_run;
    int          min_hi;

    qspi_xip_reader dut (
        .iCLK       (clk),
        .iRESETn    (rst_n),
        .iADDR      (iaddr),
        .oDATA      (odata),
        .oSTALL     (ostall),
        .oFLASH_SCK (sck),
        .oFLASH_CS  (cs),
        .oIO_OUT    (io_out),
        .oIO_OE     (io_oe),
        .iIO_IN     (io_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fb(input logic [23:0] a);
        logic [31:0] h;
        if (a == 24'h080000) return 8'h13;
        if (a >= 24'h080001 && a <= 24'h080003) return 8'h00;
        h = ({8'h00, a} ^ seed) * 32'h9E37_79B1;
        return h[23:16];
    endfunction

    function automatic logic [23:0] exp_fa(input logic [31:0] a);
        return 24'((a & 32'h00FF_FFFC) + BASE);
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] fa);
        return {fb(fa + 24'd3), fb(fa + 24'd2), fb(fa + 24'd1), fb(fa)};
    endfunction

    // Behavioural flash: decodes the 0xEB frame and streams bytes after the dummy clocks.
    initial begin
        int          rises;
        int          oe_bad;
        int          k;
        logic        in_txn;
        logic        prev_sck;
        logic [7:0]  cmd_cap;
        logic [7:0]  mode_cap;
        logic [23:0] addr_cap;
        logic [7:0]  b;
        logic [3:0]  exp_oe;
        rises = 0; oe_bad = 0; in_txn = 1'b0; prev_sck = 1'b0;
        cmd_cap = 8'h00; mode_cap = 8'h00; addr_cap = 24'h0;
        io_in = 4'h0;
        forever begin
            @(posedge clk);
            #1;
            if (cs) begin
                if (in_txn) begin
                    in_txn = 1'b0;
                    if (rises == 28) begin
                        check_val("cmd_byte", {24'h0, cmd_cap}, 32'h0000_00EB);
                        check_val("mode_byte", {24'h0, mode_cap}, 32'h0000_00FF);
                        check_val("pin_dir", oe_bad, 0);
                        fa_log.push_back(addr_cap);
                    end else begin
                        n_abort++;
                    end
                end
                hi_run++;
                rises = 0;
            end else begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    n_txn++;
                    if (n_txn > 1 && hi_run < min_hi) min_hi = hi_run;
                    hi_run = 0; oe_bad = 0;
                    cmd_cap = 8'h00; mode_cap = 8'h00; addr_cap = 24'h0;
                end
                if (sck && !prev_sck) begin
                    rises++;
                    exp_oe = (rises <= 8) ? 4'b1101 : (rises <= 16) ? 4'b1111 : 4'b0000;
                    if (io_oe !== exp_oe) oe_bad++;
                    if (rises <= 8) begin
                        cmd_cap = {cmd_cap[6:0], io_out[0]};
                        if (io_out[3:2] !== 2'b11) oe_bad++;
                    end else if (rises <= 14) begin
                        addr_cap = {addr_cap[19:0], io_out};
                    end else if (rises <= 16) begin
                        mode_cap = {mode_cap[3:0], io_out};
                    end
                end else if (!sck && prev_sck && rises >= 20 && rises < 28) begin
                    k = rises - 20;
                    b = fb(addr_cap + 24'(k / 2));
                    io_in = (k % 2 == 0) ? b[7:4] : b[3:0];
                end
            end
            prev_sck = sck;
        end
    end

    // Present an address, count stalled cycles and compare against the buffer model.
    task automatic fetch(input logic [31:0] a, input int miss_lat);
        int          n;
        logic        hit_e;
        logic [23:0] fa;
        hit_e = buf_valid && (buf_tag == a[23:2]);
        iaddr = a;
        #1;
        n = 0;
        while (ostall === 1'b1 && n < LAT_BOUND) begin
            n++;
            @(negedge clk);
        end
        check_val("stall_cycles", n, hit_e ? 0 : miss_lat);
        if (!hit_e) begin
            fa = exp_fa(a);
            buf_valid = 1'b1;
            buf_tag   = a[23:2];
            buf_word  = exp_word(fa);
            if (fa_log.size() == 0) check_val("flash_txn_seen", 0, 1);
            else check_val("flash_addr", {8'h0, fa_log.pop_front()}, {8'h0, fa});
        end
        check_val("odata", odata, buf_word);
        last_addr = a;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          txn_before;
        logic [7:0]  r8;
        logic [1:0]  r2;
        logic [31:0] a;
        n_vec = 0; n_err = 0;
        seed = $urandom;
        buf_valid = 1'b0; buf_tag = 22'd0; buf_word = 32'd0; last_addr = 32'd0;
        n_txn = 0; n_abort = 0; hi_run = 0; min_hi = 1000000;
        rst_n = 1'b0;
        iaddr = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst_cs", cs, 1);
        check_val("rst_sck", sck, 0);
        check_val("rst_oe", io_oe, 32'hC);
        check_val("rst_out", io_out, 32'hC);
        check_val("rst_data", odata, 0);
        check_val("rst_stall", ostall, 1);
        rst_n = 1'b1;

        fetch(32'h0000_0000, MISS_LAT);
        check_val("first_word", odata, 32'h0000_0013);
        // Next word requested in the first cycle after the fill: waits out CS-high time.
        fetch(32'h0000_0004, MISS_LAT + CS_HIGH);

        txn_before = n_txn;
        for (int i = 5; i < 8; i++) begin
            fetch(32'(i), MISS_LAT);
            check_val("same_word_stall", ostall, 0);
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check_val("no_cs_activity", n_txn, txn_before);

        fetch(32'h00FF_FFFC, MISS_LAT);

        for (int i = 0; i < 8; i++) begin
            repeat (6) @(negedge clk);
            a = $urandom;
            if (i % 3 == 1) begin
                r8 = 8'($urandom);
                r2 = 2'($urandom);
                a = {r8, last_addr[23:2], r2};
            end
            fetch(a, MISS_LAT);
        end

        // Address moves during the ADDR phase: first fill completes, then a second fetch.
        repeat (6) @(negedge clk);
        iaddr = 32'h0000_0010;
        #1;
        n = 0;
        while (ostall === 1'b1 && n < LAT_BOUND) begin
            n++;
            if (n == 22) iaddr = 32'h0000_0020;
            @(negedge clk);
            if (n == MISS_LAT) check_val("mid_fill_word", odata, exp_word(exp_fa(32'h10)));
        end
        check_val("redirect_stall", n, 2 * MISS_LAT + CS_HIGH);
        check_val("redirect_data", odata, exp_word(exp_fa(32'h20)));
        if (fa_log.size() != 2) check_val("redirect_txns", fa_log.size(), 2);
        else begin
            check_val("redirect_fa0", {8'h0, fa_log.pop_front()}, 32'h0008_0010);
            check_val("redirect_fa1", {8'h0, fa_log.pop_front()}, 32'h0008_0020);
        end
        buf_valid = 1'b1; buf_tag = 22'h8; buf_word = exp_word(exp_fa(32'h20));

        // Reset asserted in the middle of the DATA phase.
        repeat (6) @(negedge clk);
        iaddr = 32'h0000_0040;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        iaddr = 32'h0000_0020;
        #1;
        check_val("async_cs", cs, 1);
        check_val("rst_valid_clr", ostall, 1);
        check_val("rst_data_clr", odata, 0);
        buf_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fetch(32'h0000_0010, MISS_LAT);

        check_val("aborted_txns", n_abort, 1);
        check_val("cs_high_min_ok", (min_hi >= CS_HIGH) ? 1 : 0, 1);
        check_val("leftover_txns", fa_log.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
